// File: rtl/load_store_unit_if.sv
// Core-side request/response and ram-side bus of the load/store unit.
// slave = the unit itself, master = core plus ram that drive it.
interface load_store_unit_if #(
    parameter int ADDR_W = 30
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store stage onto a word ram; sub-word stores by read-modify-write.
// Latency accept->resp: word store 1, load 2, sub-word store 2, misalign error 1.
// One request in flight: req_ready only in IDLE; response pulse has no back-pressure.
// Optional LSU_MISALIGN_CHECK_EN: flag misaligned half/word instead of force-aligning.
module load_store_unit #(
    parameter int ADDR_W = 30
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        r_we, r_uns, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    logic        accept, a_byte, a_half, a_word, acc_err;
    logic [31:0] addr_al;
    logic [31:0] lane_shift, merged, wr_word, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        a_byte  = (bus.req_size == 2'b00);
        a_half  = (bus.req_size == 2'b01);
        a_word  = !a_byte && !a_half;
        addr_al = bus.req_addr;
        acc_err = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        acc_err = (a_half && bus.req_addr[0]) || (a_word && (bus.req_addr[1:0] != 2'b00));
`else
        if (a_half) addr_al[0]   = 1'b0;
        if (a_word) addr_al[1:0] = 2'b00;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_err   <= acc_err;
                r_size  <= bus.req_size;
                r_addr  <= addr_al;
                r_wdata <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (acc_err)                   state_nxt = RESP;
                else if (bus.req_we && a_word) state_nxt = WR;
                else                           state_nxt = RD;
            end
            RD:      state_nxt = r_we ? WR : RESP;
            WR:      state_nxt = IDLE;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_rdata holds the addressed word in the cycle after RD, i.e. in WR/RESP.
    always_comb begin
        lane_shift = bus.mem_rdata >> {r_addr[1:0], 3'b000};
        ld_byte    = lane_shift[7:0];
        ld_half    = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        if (r_size == 2'b00)
            ld_ext = {{24{!r_uns && ld_byte[7]}}, ld_byte};
        else if (r_size == 2'b01)
            ld_ext = {{16{!r_uns && ld_half[15]}}, ld_half};
        else
            ld_ext = bus.mem_rdata;

        merged = bus.mem_rdata;
        if (r_size == 2'b00)
            merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        wr_word = r_size[1] ? r_wdata : merged;
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.mem_addr   = r_addr[ADDR_W+1:2];
        bus.mem_we     = (state == WR);
        bus.mem_wdata  = (state == WR) ? wr_word : 32'h0;
        bus.resp_valid = (state == WR) || (state == RESP);
        bus.resp_err   = (state == RESP) && r_err;
        bus.resp_rdata = ((state == RESP) && !r_err) ? ld_ext : 32'h0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word ram model.
module tb_load_store_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    load_store_unit_if #(.ADDR_W(30)) bus ();
    load_store_unit #(.ADDR_W(30)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [31:0] ram [0:255];
    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    int we_cnt = 0;
    always @(negedge clock) if (bus.mem_we === 1'b1) we_cnt++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int nw);
        int w0;
        @(negedge clock);
        bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        w0 = we_cnt;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat = 0; rd = 'x; er = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (bus.resp_valid === 1'b1) begin
                lat = c; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
        end
        @(posedge clock);
        #1 nw = we_cnt - w0;
    endtask

    int          lat, nw, w0;
    logic [31:0] rd;
    logic        er;
    logic [31:0] got [0:2];
    int          acc_cyc [0:2];
    logic [31:0] l6_addr [0:2];
    logic [1:0]  l6_size [0:2];

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        // reset state
        #12;
        chk("rst_req_ready",  {31'h0, bus.req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_err",   {31'h0, bus.resp_err}, 32'h0);
        chk("rst_mem_we",     {31'h0, bus.mem_we}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_addr",   {2'b00, bus.mem_addr}, 32'h0);
        chk("rst_mem_wdata",  bus.mem_wdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // 1: word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er, nw);
        chk("t1_st_lat", lat, 1);
        chk("t1_st_we",  nw, 1);
        chk("t1_st_rd",  rd, 32'h0);
        chk("t1_st_err", {31'h0, er}, 32'h0);
        chk("t1_ram",    ram[8'h40], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er, nw);
        chk("t1_ld_lat", lat, 2);
        chk("t1_ld_rd",  rd, 32'hDEADBEEF);
        chk("t1_ld_err", {31'h0, er}, 32'h0);
        chk("t1_ld_we",  nw, 0);

        // 2: byte store + signed/unsigned byte loads
        do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h123456AA, lat, rd, er, nw);
        chk("t2_st_lat", lat, 2);
        chk("t2_st_we",  nw, 1);
        chk("t2_ram",    ram[8'h40], 32'hDEADAAEF);
        do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, rd, er, nw);
        chk("t2_lb_s",   rd, 32'hFFFFFFAA);
        do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, lat, rd, er, nw);
        chk("t2_lb_u",   rd, 32'h000000AA);

        // 3: half store + half loads on both lanes
        do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFF1234, lat, rd, er, nw);
        chk("t3_st_lat", lat, 2);
        chk("t3_ram",    ram[8'h40], 32'h1234AAEF);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rd, er, nw);
        chk("t3_lh_hi",  rd, 32'h00001234);
        do_req(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, lat, rd, er, nw);
        chk("t3_lh_lo",  rd, 32'hFFFFAAEF);

        // 4: misaligned half load
        do_req(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, lat, rd, er, nw);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("t4_lat", lat, 1);
        chk("t4_err", {31'h0, er}, 32'h1);
        chk("t4_rd",  rd, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h55555555, lat, rd, er, nw);
        chk("t4_sw_err", {31'h0, er}, 32'h1);
        chk("t4_sw_we",  nw, 0);
`else
        chk("t4_lat", lat, 2);
        chk("t4_err", {31'h0, er}, 32'h0);
        chk("t4_rd",  rd, 32'h00001234);
`endif
        chk("t4_ram", ram[8'h40], 32'h1234AAEF);

        // 5: reset while a byte store is in RD
        @(negedge clock);
        bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h100; bus.req_wdata = 32'h000000FF; bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        w0 = we_cnt;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_ready",     {31'h0, bus.req_ready}, 32'h1);
        chk("t5_resp_vld",  {31'h0, bus.resp_valid}, 32'h0);
        chk("t5_mem_we",    {31'h0, bus.mem_we}, 32'h0);
        chk("t5_mem_addr",  {2'b00, bus.mem_addr}, 32'h0);
        chk("t5_mem_wdata", bus.mem_wdata, 32'h0);
        chk("t5_rdata",     bus.resp_rdata, 32'h0);
        repeat (3) @(negedge clock);
        chk("t5_no_we",     we_cnt - w0, 0);
        chk("t5_ram",       ram[8'h40], 32'h1234AAEF);

        // 6: three back-to-back loads with req_valid held
        do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344, lat, rd, er, nw);
        do_req(1'b1, 2'b10, 1'b0, 32'h108, 32'h80000001, lat, rd, er, nw);
        l6_addr[0] = 32'h100; l6_size[0] = 2'b10;
        l6_addr[1] = 32'h104; l6_size[1] = 2'b10;
        l6_addr[2] = 32'h108; l6_size[2] = 2'b11;
        begin
            int idx, nresp, pend;
            idx = 0; nresp = 0;
            @(negedge clock);
            bus.req_we = 1'b0; bus.req_unsigned = 1'b1; bus.req_wdata = '0;
            bus.req_addr = l6_addr[0]; bus.req_size = l6_size[0]; bus.req_valid = 1'b1;
            for (int cyc = 0; cyc < 30; cyc++) begin
                if (cyc != 0) @(negedge clock);
                if (bus.resp_valid === 1'b1) begin
                    if (nresp < 3) got[nresp] = bus.resp_rdata;
                    nresp++;
                end
                pend = (bus.req_valid && bus.req_ready === 1'b1) ? 1 : 0;
                @(posedge clock);
                #1;
                if (pend == 1 && idx < 3) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                    if (idx < 3) begin
                        bus.req_addr = l6_addr[idx]; bus.req_size = l6_size[idx];
                    end else begin
                        bus.req_valid = 1'b0;
                    end
                end
            end
            chk("t6_accepts", idx, 3);
            chk("t6_resps",   nresp, 3);
            chk("t6_d0", got[0], 32'h1234AAEF);
            chk("t6_d1", got[1], 32'h11223344);
            chk("t6_d2", got[2], 32'h80000001);
            chk("t6_gap01", acc_cyc[1] - acc_cyc[0], 3);
            chk("t6_gap12", acc_cyc[2] - acc_cyc[1], 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
